// File: rtl/unidad_carga_almacen.sv
// Load/store unit between the core and a fixed-latency data memory.
// Handles byte/half/word loads with extension and sub-word stores via read-modify-write.
module unidad_carga_almacen #(
    parameter int LAT_LECTURA = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inicio,
    input  logic        EscrMemIn,
    input  logic        LeerMemIn,
    input  logic [1:0]  Tam,
    input  logic        SinSigno,
    input  logic [31:0] DirecIn,
    input  logic [31:0] DatoEscr,
    input  logic [31:0] Dataout,
    output logic [31:0] Direc,
    output logic [31:0] Datain,
    output logic        EscrMem,
    output logic        LeerMem,
    output logic [31:0] DatoLeido,
    output logic        ocupado,
    output logic        listo,
    output logic        error_alin
);

    typedef enum logic [1:0] {REPOSO, LECTURA, ESCRITURA, FIN} estado_t;

    localparam logic [2:0] ULTIMO_CICLO = 3'(LAT_LECTURA - 1);

    estado_t     state_reg, state_next;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] dato_leido_reg;
    logic [1:0]  tam_reg;
    logic        sin_signo_reg;
    logic        es_carga_reg;
    logic        err_reg;
    logic [2:0]  cnt_reg;

    logic        ilegal;
    logic        fin_lectura;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] extendido;
    logic [31:0] fusionado;

    assign ilegal = (EscrMemIn == LeerMemIn)
                 || (Tam == 2'b11)
                 || (Tam == 2'b01 && DirecIn[0])
                 || (Tam == 2'b10 && DirecIn[1:0] != 2'b00);

    assign fin_lectura = (state_reg == LECTURA) && (cnt_reg == ULTIMO_CICLO);

    // Lane extraction for loads
    always_comb begin
        byte_sel = Dataout[7:0];
        case (addr_reg[1:0])
            2'd0: byte_sel = Dataout[7:0];
            2'd1: byte_sel = Dataout[15:8];
            2'd2: byte_sel = Dataout[23:16];
            2'd3: byte_sel = Dataout[31:24];
            default: byte_sel = Dataout[7:0];
        endcase
    end

    assign half_sel = addr_reg[1] ? Dataout[31:16] : Dataout[15:0];

    always_comb begin
        extendido = Dataout;
        case (tam_reg)
            2'b00:   extendido = {{24{~sin_signo_reg & byte_sel[7]}}, byte_sel};
            2'b01:   extendido = {{16{~sin_signo_reg & half_sel[15]}}, half_sel};
            default: extendido = Dataout;
        endcase
    end

    // Read-modify-write merge: addressed lanes take store data, the rest keep memory
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_carril
            logic       carril_en;
            logic [7:0] carril_dato;
            assign carril_en = (tam_reg == 2'b00) ? (addr_reg[1:0] == 2'(gi))
                                                  : (addr_reg[1] == 1'(gi / 2));
            assign carril_dato = (tam_reg == 2'b00 || (gi % 2) == 0) ? wdata_reg[7:0]
                                                                     : wdata_reg[15:8];
            assign fusionado[8*gi +: 8] = carril_en ? carril_dato : Dataout[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            REPOSO: begin
                if (inicio) begin
                    if (ilegal)
                        state_next = FIN;
                    else if (LeerMemIn || Tam != 2'b10)
                        state_next = LECTURA;
                    else
                        state_next = ESCRITURA;
                end
            end
            LECTURA: begin
                if (fin_lectura)
                    state_next = es_carga_reg ? FIN : ESCRITURA;
            end
            ESCRITURA: state_next = FIN;
            FIN:       state_next = REPOSO;
            default:   state_next = REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= REPOSO;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            dato_leido_reg <= '0;
            tam_reg        <= '0;
            sin_signo_reg  <= 1'b0;
            es_carga_reg   <= 1'b0;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                REPOSO: begin
                    if (inicio) begin
                        addr_reg      <= DirecIn;
                        wdata_reg     <= DatoEscr;
                        tam_reg       <= Tam;
                        sin_signo_reg <= SinSigno;
                        es_carga_reg  <= LeerMemIn;
                        err_reg       <= ilegal;
                        cnt_reg       <= '0;
                    end
                end
                LECTURA: begin
                    if (fin_lectura) begin
                        if (es_carga_reg)
                            dato_leido_reg <= extendido;
                        else
                            wdata_reg <= fusionado;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign LeerMem    = (state_reg == LECTURA);
    assign EscrMem    = (state_reg == ESCRITURA);
    assign Direc      = (LeerMem || EscrMem) ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign Datain     = EscrMem ? wdata_reg : 32'd0;
    assign DatoLeido  = dato_leido_reg;
    assign ocupado    = (state_reg != REPOSO);
    assign listo      = (state_reg == FIN);
    assign error_alin = listo && err_reg;

endmodule

// File: tb/tb_unidad_carga_almacen.sv
// Bench for unidad_carga_almacen: table of transactions against a latency-accurate memory
// model, with a scoreboard queue, plus reset-abort and back-to-back sequences.
module tb_unidad_carga_almacen;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio;
    logic        EscrMemIn;
    logic        LeerMemIn;
    logic [1:0]  Tam;
    logic        SinSigno;
    logic [31:0] DirecIn;
    logic [31:0] DatoEscr;
    logic [31:0] Dataout;
    logic [31:0] Direc;
    logic [31:0] Datain;
    logic        EscrMem;
    logic        LeerMem;
    logic [31:0] DatoLeido;
    logic        ocupado;
    logic        listo;
    logic        error_alin;

    unidad_carga_almacen #(.LAT_LECTURA(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio),
        .EscrMemIn(EscrMemIn), .LeerMemIn(LeerMemIn), .Tam(Tam), .SinSigno(SinSigno),
        .DirecIn(DirecIn), .DatoEscr(DatoEscr), .Dataout(Dataout),
        .Direc(Direc), .Datain(Datain), .EscrMem(EscrMem), .LeerMem(LeerMem),
        .DatoLeido(DatoLeido), .ocupado(ocupado), .listo(listo), .error_alin(error_alin)
    );

    always #5 clk = ~clk;

    // Memory model: the word is only valid in the LAT-th cycle of a read, junk otherwise
    logic [31:0] mem_word;
    int          rd_cnt;
    always @(posedge clk) begin
        if (LeerMem) rd_cnt <= rd_cnt + 1;
        else         rd_cnt <= 0;
    end
    assign Dataout = (LeerMem && rd_cnt == LAT - 1) ? mem_word : 32'h5A5A_A5A5;

    typedef struct {
        string       name;
        logic        escr;
        logic        leer;
        logic [1:0]  tam;
        logic        sinsig;
        logic [31:0] dir;
        logic [31:0] dato;
        logic [31:0] mem;
        logic        exp_err;
        int          exp_lat;
        int          exp_reads;
        int          exp_writes;
        logic [31:0] exp_direc;
        logic [31:0] exp_datain;
        logic [31:0] exp_leido;
    } vec_t;

    typedef struct {
        logic        err;
        int          lat;
        int          reads;
        int          writes;
        logic [31:0] datain;
        logic [31:0] leido;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_vec(input vec_t v);
        int          reads = 0;
        int          writes = 0;
        int          lat = -1;
        logic        err_seen = 1'b0;
        logic        bad_direc = 1'b0;
        logic        bad_busy = 1'b0;
        logic        overlap = 1'b0;
        logic [31:0] datain_seen = 32'd0;
        logic        done = 1'b0;
        exp_t        e;

        mem_word  = v.mem;
        EscrMemIn = v.escr;
        LeerMemIn = v.leer;
        Tam       = v.tam;
        SinSigno  = v.sinsig;
        DirecIn   = v.dir;
        DatoEscr  = v.dato;
        inicio    = 1'b1;
        sb_q.push_back('{v.exp_err, v.exp_lat, v.exp_reads, v.exp_writes, v.exp_datain, v.exp_leido});

        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            inicio = 1'b0;
            if (LeerMem) reads++;
            if (EscrMem) begin
                writes++;
                datain_seen = Datain;
            end
            if ((LeerMem || EscrMem) && Direc !== v.exp_direc) bad_direc = 1'b1;
            if (LeerMem && EscrMem) overlap = 1'b1;
            if (!ocupado) bad_busy = 1'b1;
            if (listo) begin
                done     = 1'b1;
                lat      = n;
                err_seen = error_alin;
            end
        end

        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no listo within 20 cycles, expected after %0d", v.name, v.exp_lat);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            check({v.name, " latency"}, lat, e.lat);
            check({v.name, " error_alin"}, {31'd0, err_seen}, {31'd0, e.err});
            check({v.name, " reads"}, reads, e.reads);
            check({v.name, " writes"}, writes, e.writes);
            check({v.name, " Datain"}, datain_seen, e.datain);
            check({v.name, " DatoLeido"}, DatoLeido, e.leido);
            check({v.name, " Direc"}, {31'd0, bad_direc}, 32'd0);
            check({v.name, " overlap"}, {31'd0, overlap}, 32'd0);
            check({v.name, " ocupado"}, {31'd0, bad_busy}, 32'd0);
        end
        $display("txn %-16s lat=%0d rd=%0d wr=%0d err=%0b Datain=%08h DatoLeido=%08h",
                 v.name, lat, reads, writes, err_seen, datain_seen, DatoLeido);

        @(negedge clk);
        check({v.name, " listo_pulse"}, {30'd0, listo, ocupado}, 32'd0);
    endtask

    vec_t vecs[16];
    vec_t v_post;
    logic [7:0] wr_mask;
    int         listo_cnt;
    logic       bad_abort;
    logic       idle;

    initial begin
        //             name            escr  leer  tam    sin   dir            dato           mem            err  lat rd wr direc          datain         leido
        vecs[0]  = '{"ld_byte_s",      1'b0, 1'b1, 2'b00, 1'b0, 32'hFFFFFF05, 32'h00000000, 32'h123480FF, 1'b0, 2, 2, 0, 32'hFFFFFF04, 32'h00000000, 32'hFFFFFF80};
        vecs[1]  = '{"ld_half_u",      1'b0, 1'b1, 2'b01, 1'b1, 32'hFFFFFF02, 32'h00000000, 32'hBEEF0000, 1'b0, 2, 2, 0, 32'hFFFFFF00, 32'h00000000, 32'h0000BEEF};
        vecs[2]  = '{"ld_word",        1'b0, 1'b1, 2'b10, 1'b0, 32'h00000010, 32'h00000000, 32'hCAFEF00D, 1'b0, 2, 2, 0, 32'h00000010, 32'h00000000, 32'hCAFEF00D};
        vecs[3]  = '{"ld_byte_u_off3", 1'b0, 1'b1, 2'b00, 1'b1, 32'h00000103, 32'h00000000, 32'h9A000000, 1'b0, 2, 2, 0, 32'h00000100, 32'h00000000, 32'h0000009A};
        vecs[4]  = '{"ld_half_s_off0", 1'b0, 1'b1, 2'b01, 1'b0, 32'h00000020, 32'h00000000, 32'h12348001, 1'b0, 2, 2, 0, 32'h00000020, 32'h00000000, 32'hFFFF8001};
        vecs[5]  = '{"st_byte_rmw",    1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFFFE03, 32'h000000AA, 32'h11223344, 1'b0, 3, 2, 1, 32'hFFFFFE00, 32'hAA223344, 32'hFFFF8001};
        vecs[6]  = '{"st_half_off0",   1'b1, 1'b0, 2'b01, 1'b0, 32'h00000040, 32'hFFFF5678, 32'hAABBCCDD, 1'b0, 3, 2, 1, 32'h00000040, 32'hAABB5678, 32'hFFFF8001};
        vecs[7]  = '{"st_half_off2",   1'b1, 1'b0, 2'b01, 1'b0, 32'h00000042, 32'h00001234, 32'hAABBCCDD, 1'b0, 3, 2, 1, 32'h00000040, 32'h1234CCDD, 32'hFFFF8001};
        vecs[8]  = '{"st_word",        1'b1, 1'b0, 2'b10, 1'b0, 32'h00000044, 32'hDEADBEEF, 32'h00000000, 1'b0, 1, 0, 1, 32'h00000044, 32'hDEADBEEF, 32'hFFFF8001};
        vecs[9]  = '{"st_byte_off1",   1'b1, 1'b0, 2'b00, 1'b0, 32'h00000051, 32'h00000077, 32'h00000000, 1'b0, 3, 2, 1, 32'h00000050, 32'h00007700, 32'hFFFF8001};
        vecs[10] = '{"st_word_misal",  1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFFFF02, 32'h12345678, 32'h00000000, 1'b1, 0, 0, 0, 32'h00000000, 32'h00000000, 32'hFFFF8001};
        vecs[11] = '{"ld_tam11",       1'b0, 1'b1, 2'b11, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 0, 0, 0, 32'h00000000, 32'h00000000, 32'hFFFF8001};
        vecs[12] = '{"both_req",       1'b1, 1'b1, 2'b00, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 0, 0, 0, 32'h00000000, 32'h00000000, 32'hFFFF8001};
        vecs[13] = '{"no_req",         1'b0, 1'b0, 2'b00, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 0, 0, 0, 32'h00000000, 32'h00000000, 32'hFFFF8001};
        vecs[14] = '{"ld_half_odd",    1'b0, 1'b1, 2'b01, 1'b0, 32'h00000033, 32'h00000000, 32'h00000000, 1'b1, 0, 0, 0, 32'h00000000, 32'h00000000, 32'hFFFF8001};
        vecs[15] = '{"ld_byte_s_pos",  1'b0, 1'b1, 2'b00, 1'b0, 32'h00000082, 32'h00000000, 32'h007F0000, 1'b0, 2, 2, 0, 32'h00000080, 32'h00000000, 32'h0000007F};
        v_post   = '{"st_word_postrst",1'b1, 1'b0, 2'b10, 1'b0, 32'h00000100, 32'h0BADF00D, 32'h00000000, 1'b0, 1, 0, 1, 32'h00000100, 32'h0BADF00D, 32'h00000000};

        rst_n = 1'b0; inicio = 1'b0; EscrMemIn = 1'b0; LeerMemIn = 1'b0; Tam = 2'b00;
        SinSigno = 1'b0; DirecIn = 32'd0; DatoEscr = 32'd0; mem_word = 32'd0; rd_cnt = 0;
        repeat (3) @(negedge clk);
        check("reset data outs", Direc | Datain | DatoLeido, 32'd0);
        check("reset ctrl outs", {27'd0, EscrMem, LeerMem, ocupado, listo, error_alin}, 32'd0);

        // Release reset and request on the very first edge after it
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Reset one cycle into a sub-word store: must abort silently
        EscrMemIn = 1'b1; LeerMemIn = 1'b0; Tam = 2'b00; DirecIn = 32'h00000060;
        DatoEscr = 32'h000000EE; mem_word = 32'h01020304; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid data outs", Direc | Datain | DatoLeido, 32'd0);
        check("rst_mid ctrl outs", {27'd0, EscrMem, LeerMem, ocupado, listo, error_alin}, 32'd0);
        bad_abort = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (EscrMem || listo || ocupado) bad_abort = 1'b1;
        end
        check("rst_mid no activity", {31'd0, bad_abort}, 32'd0);
        $display("txn %-16s aborted, activity_after_reset=%0b", "rst_mid_store", bad_abort);
        run_vec(v_post);

        // inicio held high through word stores: one access per idle visit
        EscrMemIn = 1'b1; LeerMemIn = 1'b0; Tam = 2'b10; DirecIn = 32'h00000200;
        DatoEscr = 32'h55AA55AA; inicio = 1'b1;
        wr_mask = 8'd0;
        listo_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            wr_mask[n] = EscrMem;
            if (listo) listo_cnt++;
        end
        inicio = 1'b0;
        check("b2b write pattern", {24'd0, wr_mask}, 32'h00000049);
        check("b2b listo count", listo_cnt, 3);
        $display("txn %-16s wr_mask=%08b listo=%0d", "b2b_word_store", wr_mask, listo_cnt);
        idle = 1'b0;
        for (int n = 0; n < 10 && !idle; n++) begin
            @(negedge clk);
            if (!ocupado) idle = 1'b1;
        end
        check("b2b returns idle", {31'd0, idle}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
